// File: rtl/jtag_pkg.sv
// jtag_pkg: shared definitions for the JTAG shift master.
//   - command field widths (TDI/TMS/TDO byte, bit-count field)
//   - shift-master FSM state enumeration
//   - IEEE 1149.1 TAP state enumeration with its 4-bit encodings
//   - tap_next(): TAP controller next-state function (used when
//     JTAG_TAP_TRACK_EN is defined)
package jtag_pkg;

  localparam int unsigned CMD_W = 8;  // TDI / TMS / TDO bits per command
  localparam int unsigned LEN_W = 3;  // bit count minus one

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_RESP
  } state_e;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR         = 4'h0,
    TAP_EXIT1_DR         = 4'h1,
    TAP_SHIFT_DR         = 4'h2,
    TAP_PAUSE_DR         = 4'h3,
    TAP_SELECT_IR        = 4'h4,
    TAP_UPDATE_DR        = 4'h5,
    TAP_CAPTURE_DR       = 4'h6,
    TAP_SELECT_DR        = 4'h7,
    TAP_EXIT2_IR         = 4'h8,
    TAP_EXIT1_IR         = 4'h9,
    TAP_SHIFT_IR         = 4'hA,
    TAP_PAUSE_IR         = 4'hB,
    TAP_RUN_IDLE         = 4'hC,
    TAP_UPDATE_IR        = 4'hD,
    TAP_CAPTURE_IR       = 4'hE,
    TAP_TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms_bit);
    case (s)
      TAP_TEST_LOGIC_RESET: tap_next = tms_bit ? TAP_TEST_LOGIC_RESET : TAP_RUN_IDLE;
      TAP_RUN_IDLE:         tap_next = tms_bit ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:        tap_next = tms_bit ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR:       tap_next = tms_bit ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:         tap_next = tms_bit ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:         tap_next = tms_bit ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:         tap_next = tms_bit ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:         tap_next = tms_bit ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:        tap_next = tms_bit ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:        tap_next = tms_bit ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR:       tap_next = tms_bit ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:         tap_next = tms_bit ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:         tap_next = tms_bit ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:         tap_next = tms_bit ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:         tap_next = tms_bit ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:        tap_next = tms_bit ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:              tap_next = TAP_TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_timer.sv
// jtag_tck_timer: TCK phase timer. Counts CLK_DIV clk cycles per phase and
// pulses phase_end on the last cycle of each phase.
// Ports:
//   clk, resetb  system clock, async active-low reset
//   run          high while a TCK phase (LOW or HIGH) is in progress
//   restart      phase entry; counter restarts from zero
//   phase_end    high on the final clk cycle of the current phase
module jtag_tck_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic run,
  input  logic restart,
  output logic phase_end
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign phase_end = run && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (!run || restart) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/jtag_shift_master.sv
// jtag_shift_master: shifts up to 8 TDI/TMS bits out to a JTAG header and
// captures TDO on each TCK rising edge, returning the captured byte.
// Ports:
//   clk, resetb              system clock, async active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_tdi, cmd_tms         bits to shift, LSB first
//   cmd_len                  bit count minus one
//   rsp_valid/rsp_ready      response handshake, rsp_tdo captured TDO bits
//   tck, tms, tdi / tdo      JTAG header pins
//   busy                     high whenever not idle
//   tap_state                tracked TAP state (only with JTAG_TAP_TRACK_EN)
// Optional feature macro: JTAG_TAP_TRACK_EN
module jtag_shift_master
  import jtag_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_tdi,
  input  logic [CMD_W-1:0] cmd_tms,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CMD_W-1:0] rsp_tdo,
  output logic             tck,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo,
  output logic             busy
`ifdef JTAG_TAP_TRACK_EN
  ,
  output logic [3:0]       tap_state
`endif
);

  state_e           state;
  logic [CMD_W-1:0] tdi_q;
  logic [CMD_W-1:0] tms_q;
  logic [CMD_W-1:0] cap_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] idx_nx;
  logic             accept;
  logic             run;
  logic             phase_end;

  assign accept = cmd_valid && cmd_ready;
  assign run    = (state == ST_LOW) || (state == ST_HIGH);
  assign idx_nx = idx_q + 3'd1;

  jtag_tck_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk      (clk),
    .resetb   (resetb),
    .run      (run),
    .restart  (accept || phase_end),
    .phase_end(phase_end)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tdo   <= '0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      tdi_q     <= '0;
      tms_q     <= '0;
      cap_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tdi_q     <= cmd_tdi;
            tms_q     <= cmd_tms;
            len_q     <= cmd_len;
            idx_q     <= '0;
            cap_q     <= '0;
            tdi       <= cmd_tdi[0];
            tms       <= cmd_tms[0];
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (phase_end) begin
            // TDO is sampled on the same edge that raises TCK
            cap_q[idx_q] <= tdo;
            tck          <= 1'b1;
            state        <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (phase_end) begin
            tck <= 1'b0;
            if (idx_q < len_q) begin
              idx_q <= idx_nx;
              tdi   <= tdi_q[idx_nx];
              tms   <= tms_q[idx_nx];
              state <= ST_LOW;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          // First RESP cycle publishes the byte; rsp_valid therefore rises
          // one cycle after the final TCK falling edge.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_tdo   <= cap_q;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef JTAG_TAP_TRACK_EN
  tap_state_e tap_q;

  assign tap_state = tap_q;

  // The target sees TCK rise on the LOW->HIGH edge, with tms already stable.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tap_q <= TAP_TEST_LOGIC_RESET;
    end else if ((state == ST_LOW) && phase_end) begin
      tap_q <= tap_next(tap_q, tms);
    end
  end
`endif

endmodule
